// File: rtl/ex_stage_alu.sv
// Registered execute stage: one ALU operation per cycle over valid/ready,
// single-entry output register and ZF/SF/OF condition codes.
module ex_stage_alu #(
   parameter int XLEN = 64,
   parameter int TAGW = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      in_op,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   input  logic [TAGW-1:0] in_tag,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic [TAGW-1:0] out_tag,
   output logic            out_illegal,
   output logic            cc_zf,
   output logic            cc_sf,
   output logic            cc_of
);

   localparam int SHW = $clog2(XLEN);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLL  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_SRA  = 4'd7;
   localparam logic [3:0] OP_SLT  = 4'd8;
   localparam logic [3:0] OP_SLTU = 4'd9;

   logic [SHW-1:0]  shamt_s;
   logic [XLEN-1:0] sum_s;
   logic [XLEN-1:0] diff_s;
   logic [XLEN-1:0] alu_result_s;
   logic            illegal_s;
   logic            ovf_s;
   logic            in_ready_s;
   logic            accept_s;
   logic            cc_update_s;

   logic            out_valid_r;
   logic [XLEN-1:0] out_result_r;
   logic [TAGW-1:0] out_tag_r;
   logic            out_illegal_r;
   logic            cc_zf_r;
   logic            cc_sf_r;
   logic            cc_of_r;

   // Only the low log2(XLEN) bits of B steer the shifter, so a shift by XLEN wraps to 0.
   assign shamt_s = in_b[SHW-1:0];
   assign sum_s   = in_a + in_b;
   assign diff_s  = in_a - in_b;

   assign in_ready_s  = !flush && (!out_valid_r || out_ready);
   assign accept_s    = in_valid && in_ready_s;
   assign cc_update_s = accept_s && ((in_op == OP_ADD) || (in_op == OP_SUB));

   // Operation decode and result/overflow computation.
   always_comb begin
      alu_result_s = {XLEN{1'b0}};
      illegal_s    = 1'b0;
      ovf_s        = 1'b0;
      case (in_op)
         OP_ADD: begin
            alu_result_s = sum_s;
            ovf_s = (in_a[XLEN-1] == in_b[XLEN-1]) && (sum_s[XLEN-1] != in_a[XLEN-1]);
         end
         OP_SUB: begin
            alu_result_s = diff_s;
            ovf_s = (in_a[XLEN-1] != in_b[XLEN-1]) && (diff_s[XLEN-1] != in_a[XLEN-1]);
         end
         OP_AND:  alu_result_s = in_a & in_b;
         OP_OR:   alu_result_s = in_a | in_b;
         OP_XOR:  alu_result_s = in_a ^ in_b;
         OP_SLL:  alu_result_s = in_a << shamt_s;
         OP_SRL:  alu_result_s = in_a >> shamt_s;
         OP_SRA:  alu_result_s = $signed(in_a) >>> shamt_s;
         OP_SLT:  alu_result_s = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
         OP_SLTU: alu_result_s = {{(XLEN-1){1'b0}}, (in_a < in_b)};
         default: begin
            alu_result_s = {XLEN{1'b0}};
            illegal_s    = 1'b1;
         end
      endcase
   end

   // Output register: flush empties it, otherwise load on accept or drain on consume.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r   <= 1'b0;
         out_result_r  <= {XLEN{1'b0}};
         out_tag_r     <= {TAGW{1'b0}};
         out_illegal_r <= 1'b0;
      end else if (flush) begin
         out_valid_r   <= 1'b0;
      end else if (accept_s) begin
         out_valid_r   <= 1'b1;
         out_result_r  <= alu_result_s;
         out_tag_r     <= in_tag;
         out_illegal_r <= illegal_s;
      end else if (out_ready) begin
         out_valid_r   <= 1'b0;
      end
   end

   // Condition codes follow accepted ADD/SUB only, on the same edge as the result.
   always_ff @(posedge clk) begin
      if (rst) begin
         cc_zf_r <= 1'b1;
         cc_sf_r <= 1'b0;
         cc_of_r <= 1'b0;
      end else if (cc_update_s) begin
         cc_zf_r <= (alu_result_s == {XLEN{1'b0}});
         cc_sf_r <= alu_result_s[XLEN-1];
         cc_of_r <= ovf_s;
      end
   end

   assign in_ready    = in_ready_s;
   assign out_valid   = out_valid_r;
   assign out_result  = out_result_r;
   assign out_tag     = out_tag_r;
   assign out_illegal = out_illegal_r;
   assign cc_zf       = cc_zf_r;
   assign cc_sf       = cc_sf_r;
   assign cc_of       = cc_of_r;

endmodule

// File: doc/ex_stage_alu.md
Name: ex_stage_alu

Overview:
- Registered execute stage of the 64-bit datapath.
- Accepts one decoded operation per cycle (opcode, two 64-bit operands, destination tag) over a valid/ready handshake.
- Computes the result with the add/sub, logic and shift units (shift_logical_left plus right-shift counterparts), then holds it in an output register for the memory/writeback stage.
- Maintains the architectural condition codes (ZF, SF, OF).

Parameters:
- XLEN, 64, datapath width; shift amount is log2(XLEN) bits.
- TAGW, 4, destination-register tag width, passed through unchanged.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream presents an operation
- in_ready  output  1  stage can accept this cycle
- in_op  input  4  operation code (see Behaviour)
- in_a  input  XLEN  operand A
- in_b  input  XLEN  operand B; shifts use in_b[5:0] only
- in_tag  input  TAGW  destination tag
- flush  input  1  squash held result and drop any input this cycle
- out_valid  output  1  result register holds a valid operation
- out_ready  input  1  downstream consumes the result
- out_result  output  XLEN  registered result
- out_tag  output  TAGW  registered tag
- out_illegal  output  1  registered: accepted op code was undefined
- cc_zf, cc_sf, cc_of  output  1 each  condition-code registers

Behaviour:
- Reset (rst high at a clk edge):
  - out_valid=0, out_result=0, out_tag=0, out_illegal=0.
  - cc_zf=1, cc_sf=0, cc_of=0.
  - Reset dominates flush and any handshake, and applies mid-transfer.
- Handshake:
  - in_ready = !flush && (!out_valid || out_ready). This is combinational and has no dependence on in_valid.
  - Accept = in_valid && in_ready.
  - Latency is exactly 1 cycle: the result of an op accepted at edge N is visible at out_* right after edge N.
  - Full throughput: back-to-back accepts occur while out_ready=1.
- Output register states:
  - EMPTY (out_valid=0), FULL (out_valid=1).
  - EMPTY + accept -> FULL, loading the result.
  - FULL + out_ready + accept -> FULL, loading the new result in the same cycle.
  - FULL + out_ready + no accept -> EMPTY; out_result/out_tag keep their last values.
  - FULL + !out_ready -> FULL; out_result, out_tag and out_illegal are held stable.
  - flush=1 -> EMPTY next cycle regardless of out_ready. No input is accepted that cycle, and condition codes are not updated.
- Operations (in_op), result width XLEN, all wrap modulo 2^XLEN:
  - 0 ADD a+b
  - 1 SUB a-b
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SLL a<<b[5:0]
  - 6 SRL logical right shift
  - 7 SRA arithmetic right shift (sign-fill from a[63])
  - 8 SLT: 1 if signed a<b, else 0
  - 9 SLTU: 1 if unsigned a<b, else 0
  - 10-15: result 0, out_illegal=1. The op still completes the handshake normally.
- Shifts:
  - Shift by 0 returns a unchanged.
  - in_b[63:6] is ignored (shift by 64 == shift by 0).
- Condition codes update only at an accepted ADD or SUB; every other op, stall or flush leaves them unchanged.
  - ZF = (result==0).
  - SF = result[63].
  - OF (ADD) = a[63]==b[63] && result[63]!=a[63].
  - OF (SUB) = a[63]!=b[63] && result[63]!=a[63].
  - CC updates take effect at the same edge as out_result.
- No combinational path from in_* to out_*; all out_* and cc_* are register outputs.

Test Plan:
- Reset then SLL: rst high 2 cycles; then send op=5, a=0x1234567890ABCDEF, b=8.
  - During reset: out_valid=0, cc_zf=1.
  - One cycle after accept: out_result=0x34567890ABCDEF00, out_valid=1.
- Shift edges:
  - SRA a=0x8000000000000000, b=20 -> 0xFFFFF80000000000.
  - SRL same operands -> 0x0000080000000000.
  - SLL a=0xFFFFFFFFFFFFFFFF, b=64 -> unchanged 0xFFFFFFFFFFFFFFFF.
- Flags:
  - ADD 0x7FFFFFFFFFFFFFFF+1 -> result 0x8000000000000000, SF=1, OF=1, ZF=0.
  - Then SUB 5-5 -> 0, ZF=1, SF=0, OF=0.
  - Then XOR -> flags unchanged.
- Backpressure:
  - Hold out_ready=0 after ADD 3+4 while in_valid=1 with a second op.
  - Required: out_result stays 7, in_ready=0, second op not accepted.
  - Raise out_ready: second result appears next cycle with no gap and no loss.
- Flush / illegal:
  - FULL with out_ready=0, flush=1 -> out_valid=0 next cycle; concurrent in_valid op dropped; CC unchanged.
  - op=12 -> out_result=0, out_illegal=1.
- Reset mid-operation:
  - rst asserted while FULL and stalled -> out_valid=0, out_result=0, CC at reset values at the next edge.
